scope_capture: RTL and testbench

Triggered, double-buffered capture stage that sits between the audio synth and the VGA renderer's oscilloscope overlay. It decimates the 16-bit audio sample stream on an externally supplied strobe and waits for a rising-edge trigger, so the displayed waveform is stable from frame to frame. It stores one 7-bit amplitude per strobe into a back bank, then swaps banks at frame start. It replaces the raw per-hblank sampling currently feeding the scope with a steady, per-scanline amplitude readout.

---
 rtl/scope_capture.sv | 129 ++++++++++++
 tb/tb_scope_capture.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/scope_capture.sv
// Triggered, double-buffered oscilloscope capture: decimates audio on sample_stb,
// fills the back bank after a rising-edge trigger (or timeout), and swaps banks at frame start.
module scope_capture #(
   parameter int          DEPTH      = 480,
   parameter logic [15:0] TRIG_LEVEL = 16'h8000,
   parameter int          TIMEOUT    = 1024
) (
   input  logic        clk48,
   input  logic        rst,
   input  logic [15:0] sample_in,
   input  logic        sample_stb,
   input  logic        frame_start,
   input  logic        line_req,
   output logic [6:0]  scope_sample,
   output logic        scope_valid,
   output logic        triggered
);

   localparam int AW = $clog2(DEPTH);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {ARM, CAPTURE, DONE} state_t;

   state_t          state, state_nx;
   logic            front;
   logic [15:0]     prev;
   logic [AW-1:0]   wr_ptr, rd_ptr, wr_addr;
   logic [TW-1:0]   tmo_cnt;
   logic            trig_flag;
   logic            trig_hit, we, start, swap;
   logic [6:0]      rd_data;

   logic [6:0] bank0 [DEPTH];
   logic [6:0] bank1 [DEPTH];

   always_comb begin
      trig_hit = (prev < TRIG_LEVEL) && (sample_in >= TRIG_LEVEL);
      state_nx = state;
      we       = 1'b0;
      start    = 1'b0;
      swap     = 1'b0;
      wr_addr  = wr_ptr;
      case (state)
         ARM: begin
            if (sample_stb && (trig_hit || tmo_cnt == TMO_LAST)) begin
               we       = 1'b1;
               start    = 1'b1;
               wr_addr  = '0;
               state_nx = CAPTURE;
            end
         end
         CAPTURE: begin
            if (sample_stb) begin
               we = 1'b1;
               if (wr_ptr == LAST) state_nx = DONE;
            end
         end
         DONE: begin
            // A strobe coinciding with the swap is dropped.
            if (frame_start) begin
               swap     = 1'b1;
               state_nx = ARM;
            end
         end
         default: state_nx = ARM;
      endcase
   end

   always_ff @(posedge clk48) begin
      if (rst) state <= ARM;
      else     state <= state_nx;
   end

   always_ff @(posedge clk48) begin
      if (rst) begin
         front        <= 1'b0;
         prev         <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         tmo_cnt      <= '0;
         trig_flag    <= 1'b0;
         scope_valid  <= 1'b0;
         triggered    <= 1'b0;
         scope_sample <= '0;
      end else begin
         if (state == ARM && sample_stb) begin
            prev <= sample_in;
            if (!start) tmo_cnt <= tmo_cnt + 1'b1;
         end

         if (start) begin
            wr_ptr    <= AW'(1);
            trig_flag <= trig_hit;
         end else if (we) begin
            wr_ptr <= wr_ptr + 1'b1;
         end

         if (swap) begin
            front       <= ~front;
            scope_valid <= 1'b1;
            triggered   <= trig_flag;
            tmo_cnt     <= '0;
            prev        <= sample_in;
            wr_ptr      <= '0;
         end

         // frame_start outranks line_req: pointer rewinds, output holds.
         if (frame_start) begin
            rd_ptr <= '0;
         end else if (line_req) begin
            scope_sample <= scope_valid ? rd_data : 7'd0;
            if (rd_ptr != LAST) rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rd_data = front ? bank1[rd_ptr] : bank0[rd_ptr];

   // Capture always writes the bank opposite the one being displayed.
   always_ff @(posedge clk48) begin
      if (we) begin
         if (front) bank0[wr_addr] <= sample_in[15:9];
         else       bank1[wr_addr] <= sample_in[15:9];
      end
   end

endmodule

// File: tb/tb_scope_capture.sv
// Randomized scoreboard bench for scope_capture: a queue-based capture model predicts
// every readout, frame-start and reset response; a monitor compares them as they appear.
module tb_scope_capture;

   localparam int DEPTH   = 480;
   localparam int TIMEOUT = 1024;
   localparam int TRIG    = 32768;

   logic        clk48 = 1'b0;
   logic        rst;
   logic [15:0] sample_in;
   logic        sample_stb, frame_start, line_req;
   logic [6:0]  scope_sample;
   logic        scope_valid, triggered;

   scope_capture dut (
      .clk48        (clk48),
      .rst          (rst),
      .sample_in    (sample_in),
      .sample_stb   (sample_stb),
      .frame_start  (frame_start),
      .line_req     (line_req),
      .scope_sample (scope_sample),
      .scope_valid  (scope_valid),
      .triggered    (triggered)
   );

   always #5 clk48 = ~clk48;

   typedef struct {
      int smp;
      bit vld;
      bit trg;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: the back bank is a queue that fills up, the front bank an array.
   int   front_data [DEPTH];
   int   back_q[$];
   bit   m_valid, m_trig, back_trig;
   int   m_out, m_rdp, m_arm_cnt, m_prev;

   task automatic model_step(input bit r, input bit stb, input bit fs, input bit lr, input int s);
      bit full, hit;
      if (r) begin
         m_valid = 0; m_trig = 0; m_out = 0; m_rdp = 0;
         m_arm_cnt = 0; m_prev = 0; back_q.delete();
         return;
      end
      full = (back_q.size() == DEPTH);
      if (fs) m_rdp = 0;
      else if (lr) begin
         m_out = m_valid ? front_data[m_rdp] : 0;
         if (m_rdp < DEPTH - 1) m_rdp++;
      end
      if (full && fs) begin
         foreach (front_data[i]) front_data[i] = back_q[i];
         m_valid = 1; m_trig = back_trig;
         back_q.delete(); m_arm_cnt = 0; m_prev = s;
      end else if (!full && stb) begin
         if (back_q.size() == 0) begin
            hit = (m_prev < TRIG) && (s >= TRIG);
            if (hit || m_arm_cnt == TIMEOUT - 1) begin
               back_q.push_back(s >> 9);
               back_trig = hit;
            end else m_arm_cnt++;
            m_prev = s;
         end else back_q.push_back(s >> 9);
      end
   endtask

   task automatic cyc(input bit r, input bit stb, input bit fs, input bit lr, input int s);
      exp_t e;
      rst = r; sample_stb = stb; frame_start = fs; line_req = lr; sample_in = 16'(s);
      model_step(r, stb, fs, lr, s);
      if (r || fs || lr) begin
         e.smp = m_out; e.vld = m_valid; e.trg = m_trig;
         sb.push_back(e);
      end
      @(posedge clk48);
      @(negedge clk48);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, $urandom_range(65535));
   endtask

   task automatic strobe(input int s);
      cyc(0, 1, 0, 0, s);
      idle($urandom_range(2));
   endtask

   task automatic reads(input int n);
      for (int i = 0; i < n; i++) begin
         cyc(0, 0, 0, 1, $urandom_range(65535));
         idle($urandom_range(2));
      end
   endtask

   function automatic int tri_wave(input int k, input int amp);
      int p, t, v;
      p = k % 100;
      t = (p < 50) ? (p * 2 - 50) : (150 - p * 2);
      v = TRIG + t * amp;
      if (v < 0) v = 0;
      if (v > 65535) v = 65535;
      return v;
   endfunction

   // Monitor: every cycle that carried rst, frame_start or line_req owes one response.
   always @(posedge clk48) begin
      if (rst || frame_start || line_req) begin
         #1;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL underflow: DUT event with no expected entry at %0t", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (int'(scope_sample) != e.smp) begin
               errors++;
               $display("FAIL scope_sample: got %0d expected %0d at %0t", scope_sample, e.smp, $time);
            end
            checks++;
            if (scope_valid != e.vld) begin
               errors++;
               $display("FAIL scope_valid: got %0d expected %0d at %0t", scope_valid, e.vld, $time);
            end
            checks++;
            if (triggered != e.trg) begin
               errors++;
               $display("FAIL triggered: got %0d expected %0d at %0t", triggered, e.trg, $time);
            end
         end
      end
   end

   initial begin
      int amp, v;
      // Reset, then a readout before anything was captured.
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      idle(2);
      reads(3);

      // Triangle wave crossing mid-scale once per 100 strobes.
      amp = $urandom_range(200, 600);
      for (int k = 0; k < 600; k++) strobe(tri_wave(k, amp));
      cyc(0, 0, 1, 0, 16'h1234);
      reads(500);
      cyc(0, 0, 1, 1, 0);
      reads(3);

      // Flat input below threshold: capture forced by timeout.
      cyc(1, 0, 0, 0, 0);
      for (int k = 0; k < TIMEOUT + DEPTH - 1; k++) cyc(0, 1, 0, 0, 16'h4000);
      cyc(0, 0, 1, 0, 16'h4000);
      reads(DEPTH);

      // Short capture: first frame_start must not swap, the next one must.
      strobe(16'h9000);
      for (int k = 0; k < 199; k++) strobe($urandom_range(65535));
      cyc(0, 0, 1, 0, 0);
      reads(5);
      for (int k = 0; k < 280; k++) strobe($urandom_range(65535));
      cyc(0, 0, 1, 0, 0);
      reads(10);

      // Reset mid-capture, then a full capture whose last write meets frame_start.
      strobe(16'h1000);
      strobe(16'hC000);
      for (int k = 0; k < 249; k++) strobe($urandom_range(65535));
      cyc(1, 0, 0, 0, 0);
      idle(1);
      strobe(16'h8000);
      for (int k = 0; k < 478; k++) strobe($urandom_range(65535));
      cyc(0, 1, 1, 0, $urandom_range(65535));
      reads(4);
      cyc(0, 1, 1, 0, $urandom_range(65535));
      reads(DEPTH);

      // Random mix of all events on a random-walk signal.
      v = TRIG;
      for (int k = 0; k < 8000; k++) begin
         v += int'($urandom_range(8000)) - 4000;
         if (v < 0) v = 0;
         if (v > 65535) v = 65535;
         cyc(($urandom_range(2999) == 0), ($urandom_range(1) == 0),
             ($urandom_range(199) == 0), ($urandom_range(7) == 0), v);
      end

      idle(4);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected entries left, required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
